// File: rtl/edsac_pulse_tx.sv
// edsac_pulse_tx: serialises EDSAC words into carrier pulse trains for the
// delay-line input. Each word is sent MSB first, one slot per bit, followed
// by one spacing slot that is always blank.
//
// Ports:
//   clk        system clock (81 MHz PLL)
//   n_reset    asynchronous active-low reset
//   word_in    word to transmit, sampled on the valid/ready handshake
//   word_valid word_in is valid
//   word_ready block accepts a word this cycle (IDLE or last spacing cycle)
//   out_sig    registered modulated pulse output
//   busy       high while a word is in flight
//   word_done  one-cycle strobe on the final cycle of the spacing slot
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a word, word_ready high
// S_LEAD  | quiet lead-in at the start of a slot
// S_BURST | carrier burst window (carrier only when the slot bit is 1)
// S_GAP   | quiet tail of a slot; last cycle advances to the next slot
module edsac_pulse_tx #(
  parameter int CLK_FREQ    = 81_000_000,
  parameter int MOD_FREQ    = 13_500_000,
  parameter int PULSES      = 12,
  parameter int LEAD_CYCLES = 8,
  parameter int GAP_CYCLES  = 81,
  parameter int WIDTH       = 35
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             out_sig,
  output logic             busy,
  output logic             word_done
);

  localparam int HALF         = CLK_FREQ / (2 * MOD_FREQ);
  localparam int BURST_CYCLES = PULSES * 2 * HALF;
  localparam int TMAX_A       = (LEAD_CYCLES > BURST_CYCLES) ? LEAD_CYCLES : BURST_CYCLES;
  localparam int TMAX         = (TMAX_A > GAP_CYCLES) ? TMAX_A : GAP_CYCLES;
  localparam int CNT_W        = $clog2(TMAX + 1);
  localparam int HALF_W       = $clog2(HALF + 1);
  localparam int SLOT_W       = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0]  LEAD_LOAD  = CNT_W'(LEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BURST_LOAD = CNT_W'(BURST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [HALF_W-1:0] HALF_LOAD  = HALF_W'(HALF - 1);
  localparam logic [SLOT_W-1:0] SLOT_FIRST = SLOT_W'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_BURST, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HALF_W-1:0]  half_q, half_d;
  logic               car_q, car_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic               out_q, out_d;

  logic tc;
  logic word_end;
  logic accept;
  logic cur_bit;

  assign tc       = (cnt_q == '0);
  assign word_end = (state_q == S_GAP) && tc && (slot_q == '0);
  assign accept   = word_valid && word_ready;
  // slot index 0 is the spacing slot, which never carries a pulse
  assign cur_bit  = shreg_q[WIDTH-1] && (slot_q != '0);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      half_q  <= '0;
      car_q   <= 1'b0;
      slot_q  <= '0;
      shreg_q <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      car_q   <= car_d;
      slot_q  <= slot_d;
      shreg_q <= shreg_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    car_d   = car_q;
    slot_d  = slot_q;
    shreg_d = shreg_q;
    out_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_LEAD;
          shreg_d = word_in;
          slot_d  = SLOT_FIRST;
          cnt_d   = LEAD_LOAD;
        end
      end
      S_LEAD: begin
        if (tc) begin
          // carrier phase restarts every slot, high half first
          state_d = S_BURST;
          cnt_d   = BURST_LOAD;
          half_d  = HALF_LOAD;
          car_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_BURST: begin
        out_d = cur_bit && car_q;
        if (tc) begin
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
        if (half_q == '0) begin
          half_d = HALF_LOAD;
          car_d  = ~car_q;
        end else begin
          half_d = half_q - 1'b1;
        end
      end
      S_GAP: begin
        if (!tc) begin
          cnt_d = cnt_q - 1'b1;
        end else if (slot_q != '0) begin
          state_d = S_LEAD;
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          slot_d  = slot_q - 1'b1;
          cnt_d   = LEAD_LOAD;
        end else if (accept) begin
          // back-to-back word: no idle clock between words
          state_d = S_LEAD;
          shreg_d = word_in;
          slot_d  = SLOT_FIRST;
          cnt_d   = LEAD_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    word_ready = n_reset && ((state_q == S_IDLE) || word_end);
    word_done  = word_end;
    busy       = (state_q != S_IDLE);
    out_sig    = out_q;
  end

endmodule

// File: tb/tb_edsac_pulse_tx.sv
module tb_edsac_pulse_tx;

  localparam int HALF     = 3;
  localparam int PULSES   = 12;
  localparam int LEAD     = 8;
  localparam int GAP      = 81;
  localparam int W        = 35;
  localparam int BURST    = PULSES * 2 * HALF;
  localparam int SLOT     = LEAD + BURST + GAP;
  localparam int WORD_LEN = (W + 1) * SLOT;

  logic         clk = 1'b0;
  logic         n_reset = 1'b0;
  logic [W-1:0] word_in = '0;
  logic         word_valid = 1'b0;
  logic         word_ready, out_sig, busy, word_done;

  edsac_pulse_tx #(
    .CLK_FREQ(81_000_000), .MOD_FREQ(13_500_000), .PULSES(PULSES),
    .LEAD_CYCLES(LEAD), .GAP_CYCLES(GAP), .WIDTH(W)
  ) dut (
    .clk(clk), .n_reset(n_reset), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .out_sig(out_sig), .busy(busy), .word_done(word_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: output level at time t (clocks since the first lead-in clock)
  // derived directly from slot/burst arithmetic.
  function automatic logic ref_level(input logic [W-1:0] w, input int t);
    int   slot, pos;
    logic b;
    slot = t / SLOT;
    pos  = t % SLOT;
    b    = (slot < W) ? w[W-1-slot] : 1'b0;
    return b && (pos >= LEAD) && (pos < LEAD + BURST) && ((((pos - LEAD) / HALF) % 2) == 0);
  endfunction

  logic         m_active = 1'b0;
  logic [W-1:0] m_word = '0;
  int           m_t = 0;
  logic         m_ready_prev = 1'b0;
  int           cyc = 0;
  int           hs_count = 0, hs_cycle = 0;
  int           rise_count = 0, first_rise = 0, last_rise = 0;
  int           done_count = 0, done_cycle = 0;
  logic         prev_out = 1'b0;

  always @(posedge clk) begin
    logic e_out, e_busy, e_ready, e_done;
    #1;
    cyc++;
    if (!n_reset) begin
      m_active = 1'b0;
    end else begin
      if (m_active) begin
        m_t++;
        if (m_t == WORD_LEN) m_active = 1'b0;
      end
      if (word_valid && m_ready_prev) begin
        m_active = 1'b1;
        m_word   = word_in;
        m_t      = 0;
        hs_count++;
        hs_cycle = cyc;
      end
    end
    e_busy  = m_active;
    e_done  = m_active && (m_t == WORD_LEN - 1);
    e_ready = n_reset && (!m_active || e_done);
    e_out   = m_active && (m_t >= 1) && ref_level(m_word, m_t - 1);
    chk("cycle{out,busy,ready,done}", {60'd0, out_sig, busy, word_ready, word_done},
        {60'd0, e_out, e_busy, e_ready, e_done});
    m_ready_prev = e_ready;
    if (out_sig && !prev_out) begin
      rise_count++;
      if (rise_count == 1) first_rise = cyc;
      last_rise = cyc;
    end
    prev_out = out_sig;
    if (word_done) begin
      done_count++;
      done_cycle = cyc;
    end
  end

  task automatic send(input logic [W-1:0] w);
    int h0;
    h0 = hs_count;
    word_valid = 1'b1;
    word_in    = w;
    for (int i = 0; i < 8000 && hs_count == h0; i++) @(negedge clk);
    chk("handshake_seen", 64'(hs_count != h0), 64'd1);
    word_valid = 1'b0;
    word_in    = W'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 8000 && busy; i++) @(negedge clk);
    chk("idle_reached", 64'(busy), 64'd0);
  endtask

  task automatic clr_counts();
    rise_count = 0;
    done_count = 0;
  endtask

  initial begin
    int hs1, hs2, h0;
    logic [63:0] r;

    repeat (3) @(negedge clk);
    chk("rst_out", 64'(out_sig), 64'd0);
    chk("rst_ready", 64'(word_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    n_reset = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(word_ready), 64'd1);

    // all ones
    clr_counts();
    send(35'h7_FFFF_FFFF);
    hs1 = hs_cycle;
    wait_idle();
    chk("ones_rises", 64'(rise_count), 64'd420);
    chk("ones_done_count", 64'(done_count), 64'd1);
    chk("ones_done_time", 64'(done_cycle - hs1), 64'(WORD_LEN - 1));
    chk("ones_first_rise", 64'(first_rise - hs1), 64'(LEAD + 1));
    chk("ones_last_rise", 64'(last_rise - hs1), 64'(34 * SLOT + LEAD + 1 + 11 * 2 * HALF));

    // zero word
    clr_counts();
    send('0);
    hs1 = hs_cycle;
    wait_idle();
    chk("zero_rises", 64'(rise_count), 64'd0);
    chk("zero_done_count", 64'(done_count), 64'd1);
    chk("zero_done_time", 64'(done_cycle - hs1), 64'(WORD_LEN - 1));

    // MSB only
    clr_counts();
    send(35'h4_0000_0000);
    hs1 = hs_cycle;
    wait_idle();
    chk("msb_first_rise", 64'(first_rise - hs1), 64'(LEAD + 1));
    chk("msb_rises", 64'(rise_count), 64'(PULSES));
    chk("msb_last_rise", 64'(last_rise - hs1), 64'(LEAD + 1 + (PULSES - 1) * 2 * HALF));

    // back-to-back, valid held high
    clr_counts();
    h0 = hs_count;
    word_valid = 1'b1;
    word_in    = 35'h1;
    for (int i = 0; i < 8000 && hs_count == h0; i++) @(negedge clk);
    hs1 = hs_cycle;
    word_in = 35'h7_FFFF_FFFF;
    for (int i = 0; i < 8000 && hs_count == h0 + 1; i++) @(negedge clk);
    hs2 = hs_cycle;
    word_valid = 1'b0;
    chk("b2b_second_hs", 64'(hs_count - h0), 64'd2);
    chk("b2b_spacing", 64'(hs2 - hs1), 64'(WORD_LEN));
    chk("b2b_w1_rises", 64'(rise_count), 64'(PULSES));
    chk("b2b_w1_first_rise", 64'(first_rise - hs1), 64'(34 * SLOT + LEAD + 1));
    rise_count = 0;
    wait_idle();
    chk("b2b_w2_first_rise", 64'(first_rise - hs2), 64'(LEAD + 1));
    chk("b2b_w2_rises", 64'(rise_count), 64'd420);

    // reset mid-burst, at a clock where out_sig is high
    clr_counts();
    send(35'h7_FFFF_FFFF);
    repeat (LEAD + 20) @(negedge clk);
    chk("pre_rst_out", 64'(out_sig), 64'd1);
    n_reset = 1'b0;
    #1;
    chk("async_rst_out", 64'(out_sig), 64'd0);
    chk("async_rst_ready", 64'(word_ready), 64'd0);
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    #1;
    chk("post_rst_ready", 64'(word_ready), 64'd1);
    @(negedge clk);
    clr_counts();
    send('0);
    wait_idle();
    chk("post_rst_rises", 64'(rise_count), 64'd0);

    // backpressure: word_in churns with valid high mid-word
    r = {$urandom, $urandom};
    send(r[W-1:0]);
    repeat (1000) @(negedge clk);
    h0 = hs_count;
    for (int i = 0; i < 2000; i++) begin
      word_valid = 1'b1;
      word_in    = W'({$urandom, $urandom});
      @(negedge clk);
    end
    word_valid = 1'b0;
    chk("bp_no_handshake", 64'(hs_count), 64'(h0));
    wait_idle();

    // random words with random idle gaps
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      r = {$urandom, $urandom};
      clr_counts();
      send(r[W-1:0]);
      wait_idle();
      chk("rand_rises", 64'(rise_count), 64'(PULSES * $countones(r[W-1:0])));
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
